signed_accum_stage: RTL and testbench
=====================================

SIGNED_ACCUM_STAGE -- requirements
Module: signed_accum_stage

Interface
REQ-001 SHALL provide parameter DW, default 4, as the input sample width in bits (signed).
REQ-002 SHALL provide parameter AW, default 8, as the accumulator/output width in bits (signed); AW > DW.
REQ-003 SHALL provide parameter COUNT, default 4, as the number of samples per output sum; COUNT >= 2.
REQ-004 SHALL provide port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL provide port in_valid, input, 1, upstream sample valid.
REQ-007 SHALL provide port in_ready, output, 1, stage can accept a sample.
REQ-008 SHALL provide port in_data, input, DW, signed two's-complement sample (the upstream conditional-select output).
REQ-009 SHALL provide port out_valid, output, 1, result valid.
REQ-010 SHALL provide port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL provide port out_sum, output, AW, signed sum of COUNT samples.
REQ-012 SHALL provide port out_ovf, output, 1, overflow occurred in the sum being presented.

Function
REQ-013 SHALL implement FSM states ACCUM and HOLD.
REQ-014 In ACCUM: in_ready=1 and out_valid=0.
REQ-015 In HOLD: in_ready=0 and out_valid=1.
REQ-016 SHALL accept a sample only on the cycle where in_valid && in_ready.
REQ-017 Each accepted sample SHALL be sign-extended from DW to AW and added to the accumulator; no mixed unsigned interpretation.
REQ-018 SHALL count accepted samples 0..COUNT-1.
REQ-019 On acceptance of the COUNT-th sample: transition to HOLD, with out_sum and out_ovf registered and visible the following cycle (latency 1 cycle after final accept).
REQ-020 SHALL detect overflow on each add: operands have the same sign and the result sign differs; out_ovf is sticky across the group.
REQ-021 In HOLD, out_sum and out_ovf SHALL stay stable until out_valid && out_ready.
REQ-022 On the handshake, return to ACCUM with accumulator, count and overflow cleared; in_ready rises the next cycle (no same-cycle pass-through).
REQ-023 in_valid low mid-group SHALL hold the accumulator and count unchanged, with no timeout.
REQ-024 out_ready asserted while in ACCUM SHALL have no effect.

Reset
REQ-025 rst_n low SHALL asynchronously force: state=ACCUM, accumulator=0, count=0, out_sum=0, out_ovf=0, out_valid=0.
REQ-026 in_ready SHALL be 1 after reset release.
REQ-027 Reset mid-group or during HOLD SHALL discard the partial or pending result.

Configuration
REQ-028 SHALL support macro SIGNED_ACCUM_SAT_EN.
REQ-029 When SIGNED_ACCUM_SAT_EN is defined, an overflowing add SHALL clamp the accumulator to +2^(AW-1)-1 or -2^(AW-1), and later adds continue from the clamped value.
REQ-030 When SIGNED_ACCUM_SAT_EN is undefined, the accumulator SHALL wrap modulo 2^AW.
REQ-031 out_ovf SHALL be reported identically in both builds.

Structure
REQ-032 Package signed_accum_pkg SHALL hold the FSM state enum and the default DW/AW/COUNT localparams.
REQ-033 A combinational sub-module sat_add SHALL perform the AW-bit signed add, produce the overflow flag, and apply clamping under SIGNED_ACCUM_SAT_EN.

Verification
REQ-034 Defaults; in_data -8,-8,-8,-8 with out_ready=1 -> out_sum=-32, out_ovf=0, out_valid one cycle after 4th accept, then in_ready=1 next cycle.
REQ-035 Defaults; samples 7,-1,3,-2 with in_valid gapped (1 idle cycle between each) -> out_sum=7, out_ovf=0.
REQ-036 Defaults; 4 samples of 7 then out_ready=0 for 5 cycles -> out_sum=28 held stable, in_ready=0, extra in_valid ignored; out_ready=1 -> handshake, clear.
REQ-037 AW=6, COUNT=8; eight samples of 7 -> with SIGNED_ACCUM_SAT_EN out_sum=31, out_ovf=1; without it out_sum=-8, out_ovf=1.
REQ-038 Defaults; rst_n pulsed low after 2 accepts of 5 -> all outputs 0, next 4 samples of 1 -> out_sum=4.

Source files
------------

// File: rtl/signed_accum_pkg.sv
// Shared types and default sizing for the signed accumulate stage.
// The optional SIGNED_ACCUM_SAT_EN macro is consumed by sat_add.
package signed_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEF_DW    = 4;
    localparam int DEF_AW    = 8;
    localparam int DEF_COUNT = 4;

endpackage

// File: rtl/sat_add.sv
// AW-bit signed adder with two's-complement overflow flag.
// With SIGNED_ACCUM_SAT_EN defined, an overflowing result is clamped to the signed limits.
module sat_add
    import signed_accum_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] b,
    output logic signed [AW-1:0] sum,
    output logic                 ovf
);

`ifdef SIGNED_ACCUM_SAT_EN
    // Overflow direction follows the shared operand sign.
    function automatic logic signed [AW-1:0] sat_limit(input logic neg);
        sat_limit = neg ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    endfunction
`endif

    logic signed [AW-1:0] raw;

    always_comb begin
        raw = a + b;
        ovf = (a[AW-1] == b[AW-1]) && (raw[AW-1] != a[AW-1]);
`ifdef SIGNED_ACCUM_SAT_EN
        sum = ovf ? sat_limit(a[AW-1]) : raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/signed_accum_stage.sv
// Sums COUNT signed samples and presents the total with a sticky overflow flag.
// Define SIGNED_ACCUM_SAT_EN to saturate the accumulator instead of wrapping.
module signed_accum_stage
    import signed_accum_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int COUNT = DEF_COUNT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out_sum,
    output logic                 out_ovf
);

    localparam int CW = $clog2(COUNT);

    state_t               state_p0, state_nx;
    logic signed [AW-1:0] acc_p0, sum_p1, add_sum, ext_p0;
    logic [CW-1:0]        cnt_p0;
    logic                 ovf_p0, ovf_p1, add_ovf;
    logic                 accept, last, handshake;

    assign ext_p0    = {{(AW-DW){in_data[DW-1]}}, in_data};
    assign accept    = in_valid && in_ready;
    assign last      = (cnt_p0 == CW'(COUNT-1));
    assign handshake = out_valid && out_ready;

    sat_add #(.AW(AW)) u_add (
        .a   (acc_p0),
        .b   (ext_p0),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_nx  = state_p0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_p0)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && last) state_nx = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ACCUM;
            end
            default: state_nx = ACCUM;
        endcase
    end

    // Stage p0 accumulates; stage p1 holds the finished group until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= ACCUM;
            acc_p0   <= '0;
            cnt_p0   <= '0;
            ovf_p0   <= 1'b0;
            sum_p1   <= '0;
            ovf_p1   <= 1'b0;
        end else begin
            state_p0 <= state_nx;
            if (accept) begin
                if (last) begin
                    acc_p0 <= '0;
                    cnt_p0 <= '0;
                    ovf_p0 <= 1'b0;
                    sum_p1 <= add_sum;
                    ovf_p1 <= ovf_p0 | add_ovf;
                end else begin
                    acc_p0 <= add_sum;
                    cnt_p0 <= cnt_p0 + 1'b1;
                    ovf_p0 <= ovf_p0 | add_ovf;
                end
            end
            if (handshake) begin
                sum_p1 <= '0;
                ovf_p1 <= 1'b0;
            end
        end
    end

    assign out_sum = sum_p1;
    assign out_ovf = ovf_p1;

endmodule

// File: tb/tb_signed_accum_stage.sv
// Bench for signed_accum_stage: a default instance and an AW=6/COUNT=8 instance
// checked against an integer-arithmetic reference model.
module tb_signed_accum_stage;

    logic clk = 1'b0;
    logic rst_n;

    logic              iv0, or0, ir0, ov0, of0;
    logic signed [3:0] id0;
    logic signed [7:0] os0;

    logic              iv1, or1, ir1, ov1, of1;
    logic signed [3:0] id1;
    logic signed [5:0] os1;

    int checks   = 0;
    int failures = 0;
    int mq[$];

    always #5 clk = ~clk;

    signed_accum_stage u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_sum(os0), .out_ovf(of0)
    );

    signed_accum_stage #(.DW(4), .AW(6), .COUNT(8)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_sum(os1), .out_ovf(of1)
    );

    // Reference: exact integer sum per step, out-of-range step flags overflow,
    // then the running value is clamped or wrapped depending on the build.
    function automatic void model_run(input int aw, output int s, output bit o);
        int mx = (1 << (aw - 1)) - 1;
        int mn = -(1 << (aw - 1));
        int r  = 1 << aw;
        int t;
        s = 0;
        o = 1'b0;
        foreach (mq[i]) begin
            t = s + mq[i];
            if (t > mx || t < mn) begin
                o = 1'b1;
`ifdef SIGNED_ACCUM_SAT_EN
                t = (t > mx) ? mx : mn;
`else
                t = (((t - mn) % r) + r) % r + mn;
`endif
            end
            s = t;
        end
    endfunction

    // Called at a negedge; presents one sample for one cycle, then idles gap cycles.
    task automatic drive0(input int v, input int gap);
        iv0 = 1'b1;
        id0 = 4'(v);
        @(negedge clk);
        iv0 = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drive1(input int v, input int gap);
        iv1 = 1'b1;
        id1 = 4'(v);
        @(negedge clk);
        iv1 = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv0 = 1'b0; or0 = 1'b0; id0 = '0;
        iv1 = 1'b0; or1 = 1'b0; id1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0 || os0 !== 8'sd0 || of0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b vld=%b sum=%0d ovf=%b, expected rdy=1 vld=0 sum=0 ovf=0",
                     ir0, ov0, os0, of0);
        end
        checks++;
        if (ov1 !== 1'b0 || os1 !== 6'sd0 || of1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state_wide: vld=%b sum=%0d ovf=%b, expected 0 0 0", ov1, os1, of1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ir0 !== 1'b1 || ir1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: rdy0=%b rdy1=%b, expected 1 1", ir0, ir1);
        end
    endtask

    task automatic test_min_sum();
        or0 = 1'b1;
        for (int i = 0; i < 3; i++) drive0(-8, 0);
        checks++;
        if (ov0 !== 1'b0) begin
            failures++;
            $display("FAIL min_early_valid: vld=%b after 3 samples, expected 0", ov0);
        end
        drive0(-8, 0);
        checks++;
        if (ov0 !== 1'b1 || os0 !== -8'sd32 || of0 !== 1'b0 || ir0 !== 1'b0) begin
            failures++;
            $display("FAIL min_sum: vld=%b sum=%0d ovf=%b rdy=%b, expected vld=1 sum=-32 ovf=0 rdy=0",
                     ov0, os0, of0, ir0);
        end
        @(negedge clk);
        or0 = 1'b0;
        checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
            failures++;
            $display("FAIL min_after_handshake: rdy=%b vld=%b, expected rdy=1 vld=0", ir0, ov0);
        end
    endtask

    task automatic test_gapped();
        drive0(7, 1);
        drive0(-1, 1);
        drive0(3, 1);
        drive0(-2, 0);
        checks++;
        if (ov0 !== 1'b1 || os0 !== 8'sd7 || of0 !== 1'b0) begin
            failures++;
            $display("FAIL gapped_sum: vld=%b sum=%0d ovf=%b, expected vld=1 sum=7 ovf=0", ov0, os0, of0);
        end
        or0 = 1'b1;
        @(negedge clk);
        or0 = 1'b0;
        checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
            failures++;
            $display("FAIL gapped_release: rdy=%b vld=%b, expected rdy=1 vld=0", ir0, ov0);
        end
    endtask

    task automatic test_hold();
        or0 = 1'b0;
        for (int i = 0; i < 4; i++) drive0(7, 0);
        for (int c = 0; c < 5; c++) begin
            iv0 = 1'b1;
            id0 = 4'sd3;
            @(negedge clk);
            checks++;
            if (ov0 !== 1'b1 || os0 !== 8'sd28 || of0 !== 1'b0 || ir0 !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: vld=%b sum=%0d ovf=%b rdy=%b, expected vld=1 sum=28 ovf=0 rdy=0",
                         c, ov0, os0, of0, ir0);
            end
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        @(negedge clk);
        or0 = 1'b0;
        checks++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: vld=%b rdy=%b, expected vld=0 rdy=1", ov0, ir0);
        end
        for (int i = 0; i < 4; i++) drive0(1, 0);
        checks++;
        if (ov0 !== 1'b1 || os0 !== 8'sd4 || of0 !== 1'b0) begin
            failures++;
            $display("FAIL hold_next_group: vld=%b sum=%0d ovf=%b, expected vld=1 sum=4 ovf=0", ov0, os0, of0);
        end
        or0 = 1'b1;
        @(negedge clk);
        or0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive0(5, 0);
        drive0(5, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b0 || os0 !== 8'sd0 || of0 !== 1'b0 || ir0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_group: vld=%b sum=%0d ovf=%b rdy=%b, expected 0 0 0 1", ov0, os0, of0, ir0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive0(1, 0);
        checks++;
        if (ov0 !== 1'b1 || os0 !== 8'sd4 || of0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_regroup: vld=%b sum=%0d ovf=%b, expected vld=1 sum=4 ovf=0", ov0, os0, of0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b0 || os0 !== 8'sd0 || ir0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_hold: vld=%b sum=%0d rdy=%b, expected vld=0 sum=0 rdy=1", ov0, os0, ir0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wide_overflow();
        int es;
        bit eo;
        mq.delete();
        for (int i = 0; i < 8; i++) mq.push_back(7);
        model_run(6, es, eo);
        or1 = 1'b0;
        for (int i = 0; i < 8; i++) drive1(7, 0);
        checks++;
        if (ov1 !== 1'b1 || os1 !== 6'(es) || of1 !== eo) begin
            failures++;
            $display("FAIL wide_overflow: vld=%b sum=%0d ovf=%b, expected vld=1 sum=%0d ovf=%b",
                     ov1, os1, of1, es, eo);
        end
        checks++;
`ifdef SIGNED_ACCUM_SAT_EN
        if (os1 !== 6'sd31 || of1 !== 1'b1) begin
`else
        if (os1 !== -6'sd8 || of1 !== 1'b1) begin
`endif
            failures++;
            $display("FAIL wide_overflow_const: sum=%0d ovf=%b", os1, of1);
        end
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
    endtask

    task automatic test_random();
        int es;
        bit eo;
        for (int g = 0; g < 10; g++) begin
            mq.delete();
            for (int i = 0; i < 4; i++) mq.push_back(int'($urandom_range(15)) - 8);
            model_run(8, es, eo);
            for (int i = 0; i < 4; i++) drive0(mq[i], (i == 3) ? 0 : int'($urandom_range(2)));
            repeat ($urandom_range(3)) @(negedge clk);
            checks++;
            if (ov0 !== 1'b1 || os0 !== 8'(es) || of0 !== eo) begin
                failures++;
                $display("FAIL rand_default grp%0d: vld=%b sum=%0d ovf=%b, expected vld=1 sum=%0d ovf=%b",
                         g, ov0, os0, of0, es, eo);
            end
            or0 = 1'b1;
            @(negedge clk);
            or0 = 1'b0;
        end
        for (int g = 0; g < 10; g++) begin
            mq.delete();
            for (int i = 0; i < 8; i++) mq.push_back(int'($urandom_range(15)) - 8);
            model_run(6, es, eo);
            for (int i = 0; i < 8; i++) drive1(mq[i], (i == 7) ? 0 : int'($urandom_range(1)));
            repeat ($urandom_range(3)) @(negedge clk);
            checks++;
            if (ov1 !== 1'b1 || os1 !== 6'(es) || of1 !== eo) begin
                failures++;
                $display("FAIL rand_wide grp%0d: vld=%b sum=%0d ovf=%b, expected vld=1 sum=%0d ovf=%b",
                         g, ov1, os1, of1, es, eo);
            end
            or1 = 1'b1;
            @(negedge clk);
            or1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_min_sum();
        test_gapped();
        test_hold();
        test_reset_mid();
        test_wide_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
